// File: rtl/usb_pc_event_ctrl_if.sv
// ---------------------------------------------------------------------------
// usb_pc_event_ctrl_if
// Avalon-MM slave bus and level interrupt of the USB/PC event scheduler.
//   address    [1:0]  register select
//   chipselect        slave select
//   write_n           write strobe, active-low
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data (one-cycle latency)
//   irq               registered level interrupt to the CPU
// master: CPU side (drives the bus). slave: the event controller.
// ---------------------------------------------------------------------------
interface usb_pc_event_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/usb_pc_event_ctrl.sv
// ---------------------------------------------------------------------------
// usb_pc_event_ctrl
// Synchronizes and debounces WIDTH asynchronous status lines, captures their
// rising edges into pending bits and hands them to the CPU one at a time,
// round-robin, behind a level interrupt. Each event is retired by a write to
// the event register.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave + irq (usb_pc_event_ctrl_if.slave)
//   in_port  [WIDTH-1:0] asynchronous status lines
//
// Register map:
//   0  R   {0, stable}
//   1  RW  bit 31 irq_en, bits [WIDTH-1:0] enable mask
//   2  R   bit 31 valid, bits [2:0] channel;  W any value = acknowledge
//   3  R   {0, pending};  W1C pending bits
// ---------------------------------------------------------------------------
module usb_pc_event_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    usb_pc_event_ctrl_if.slave bus,
    input  logic [WIDTH-1:0]   in_port
);

    localparam int             CW        = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]     LAST_INIT = 3'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        RELEASE
    } state_t;

    // Input conditioning
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_q;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] rise;

    // Event capture and control
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] mask;
    logic             irq_en;

    // Scheduler
    state_t           state;
    state_t           state_next;
    logic             valid;
    logic             valid_next;
    logic [2:0]       channel;
    logic [2:0]       channel_next;
    logic [2:0]       last;
    logic [2:0]       last_next;
    logic [WIDTH-1:0] grant_clr;
    logic             found;
    logic [2:0]       pick;
    logic [WIDTH-1:0] req;

    // Bus decode
    logic             wr;
    logic             wr_ctrl;
    logic             wr_ack;
    logic             wr_w1c;
    logic [WIDTH-1:0] w1c_bits;
    logic [31:0]      rd_mux;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign wr_ctrl  = wr && (bus.address == 2'd1);
    assign wr_ack   = wr && (bus.address == 2'd2);
    assign wr_w1c   = wr && (bus.address == 2'd3);
    assign w1c_bits = wr_w1c ? bus.writedata[WIDTH-1:0] : '0;

    // -----------------------------------------------------------------------
    // Two-stage synchronizer
    // -----------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // sample pre-edge values; blocking here would collapse sync1->sync2 into
    // a single stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce: a level change is accepted only after sync2 has differed
    // from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    // -----------------------------------------------------------------------
    // NOTE: the counter array is a handful of flops, not a RAM, so it is
    // reset along with everything else; a real memory would not be.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Rising-edge capture. The set term is OR-ed in last so a new edge wins
    // over a grant or W1C clearing the same bit in the same cycle.
    // -----------------------------------------------------------------------
    assign rise = stable & ~stable_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= '0;
            pending  <= '0;
        end else begin
            stable_q <= stable;
            pending  <= (pending & ~(grant_clr | w1c_bits)) | rise;
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: first requesting channel after 'last', with wrap.
    // -----------------------------------------------------------------------
    assign req = pending & mask;

    // NOTE: outputs of combinational blocks get a default before any branch
    // so no path leaves them unassigned, which would infer a latch.
    always_comb begin
        found = 1'b0;
        pick  = last;
        for (int k = 1; k <= WIDTH; k++) begin
            if (!found && req[(int'(last) + k) % WIDTH]) begin
                found = 1'b1;
                pick  = 3'((int'(last) + k) % WIDTH);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scheduler FSM: next state and event register updates
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        valid_next   = valid;
        channel_next = channel;
        last_next    = last;
        grant_clr    = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    valid_next   = 1'b1;
                    channel_next = pick;
                    last_next    = pick;
                    grant_clr    = WIDTH'(1) << pick;
                    state_next   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // The held event is independent of later mask/pending changes.
                if (wr_ack) begin
                    valid_next = 1'b0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                // One dead cycle guarantees irq drops between events.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            valid   <= 1'b0;
            channel <= '0;
            last    <= LAST_INIT;
        end else begin
            state   <= state_next;
            valid   <= valid_next;
            channel <= channel_next;
            last    <= last_next;
        end
    end

    // -----------------------------------------------------------------------
    // Control register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask   <= '0;
            irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            mask   <= bus.writedata[WIDTH-1:0];
            irq_en <= bus.writedata[31];
        end
    end

    // -----------------------------------------------------------------------
    // Read mux, registered every cycle regardless of chipselect
    // -----------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            2'd0: rd_mux[WIDTH-1:0] = stable;
            2'd1: begin
                rd_mux[WIDTH-1:0] = mask;
                rd_mux[31]        = irq_en;
            end
            2'd2: begin
                rd_mux[2:0] = channel;
                rd_mux[31]  = valid;
            end
            default: rd_mux[WIDTH-1:0] = pending;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
            bus.irq      <= 1'b0;
        end else begin
            bus.readdata <= rd_mux;
            bus.irq      <= irq_en & valid;
        end
    end

endmodule

// File: tb/tb_usb_pc_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_usb_pc_event_ctrl
// Directed bench for usb_pc_event_ctrl with WIDTH=4, DEBOUNCE_CYCLES=4.
// Inputs are driven 1 ns after the rising edge and outputs are sampled there
// too, so "after edge n" below means the state right after rising edge n.
// ---------------------------------------------------------------------------
module tb_usb_pc_event_ctrl;

    logic       clk;
    logic       reset_n;
    logic [3:0] in_port;

    int n_checks;
    int n_fail;

    usb_pc_event_ctrl_if bus ();

    usb_pc_event_ctrl #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = data;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus.address    = 2'd2;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        tick();
        data        = bus.readdata;
        bus.address = 2'd2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Poll the event register (address 2 held) until valid shows, bounded.
    task automatic wait_event(input logic [31:0] exp, input logic exp_irq, input string name);
        bit got;
        got = 1'b0;
        bus.address = 2'd2;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (bus.readdata[31]) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            $display("FAIL %s: no event within 40 cycles, expected %h", name, exp);
            n_fail++;
        end else begin
            if (bus.readdata !== exp) begin
                $display("FAIL %s: event got %h expected %h", name, bus.readdata, exp);
                n_fail++;
            end
            n_checks++;
            if (bus.irq !== exp_irq) begin
                $display("FAIL %s irq: got %b expected %b", name, bus.irq, exp_irq);
                n_fail++;
            end
        end
    endtask

    // Acknowledge at edge k; after k+1 irq must be low and valid cleared.
    task automatic ack_event(input string name);
        bus_write(2'd2, 32'h0);
        tick();
        n_checks++;
        if (bus.irq !== 1'b0) begin
            $display("FAIL %s ack irq: got %b expected 0", name, bus.irq);
            n_fail++;
        end
        n_checks++;
        if (bus.readdata[31] !== 1'b0) begin
            $display("FAIL %s ack valid: got %b expected 0", name, bus.readdata[31]);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        in_port        = '0;
        bus.address    = 2'd2;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        #1;
        n_checks++;
        if (bus.readdata !== 32'h0) begin
            $display("FAIL reset readdata: got %h expected 0", bus.readdata);
            n_fail++;
        end
        n_checks++;
        if (bus.irq !== 1'b0) begin
            $display("FAIL reset irq: got %b expected 0", bus.irq);
            n_fail++;
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (dut.pending !== 4'h0 || dut.valid !== 1'b0) begin
            $display("FAIL reset state: pending %h valid %b expected 0 0", dut.pending, dut.valid);
            n_fail++;
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        do_reset();
        bus_write(2'd1, 32'h8000_000F);
        // 3-cycle glitch on channel 1
        in_port[1] = 1'b1;
        repeat (3) tick();
        in_port[1] = 1'b0;
        repeat (12) tick();
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h0) begin
            $display("FAIL glitch pending: got %h expected 0", d);
            n_fail++;
        end
        n_checks++;
        if (bus.irq !== 1'b0) begin
            $display("FAIL glitch irq: got %b expected 0", bus.irq);
            n_fail++;
        end
        // Held rise, launched right after edge 0
        in_port[1] = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (dut.pending !== 4'h0) begin
            $display("FAIL rise pending@6: got %h expected 0", dut.pending);
            n_fail++;
        end
        tick();
        n_checks++;
        if (dut.pending !== 4'h2) begin
            $display("FAIL rise pending@7: got %h expected 2", dut.pending);
            n_fail++;
        end
        tick();
        n_checks++;
        if (dut.valid !== 1'b1 || dut.channel !== 3'd1 || bus.irq !== 1'b0) begin
            $display("FAIL rise event@8: valid %b ch %0d irq %b expected 1 1 0",
                     dut.valid, dut.channel, bus.irq);
            n_fail++;
        end
        tick();
        n_checks++;
        if (bus.irq !== 1'b1 || bus.readdata !== 32'h8000_0001) begin
            $display("FAIL rise irq@9: irq %b readdata %h expected 1 80000001",
                     bus.irq, bus.readdata);
            n_fail++;
        end
        ack_event("debounce");
    endtask

    task automatic test_round_robin();
        logic [31:0] d;
        do_reset();
        bus_write(2'd1, 32'h8000_0000);
        in_port = 4'b1011;
        repeat (12) tick();
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'hB) begin
            $display("FAIL rr pending: got %h expected b", d);
            n_fail++;
        end
        bus_write(2'd1, 32'h8000_000F);
        wait_event(32'h8000_0000, 1'b1, "rr grant0");
        ack_event("rr0");
        wait_event(32'h8000_0001, 1'b1, "rr grant1");
        ack_event("rr1");
        wait_event(32'h8000_0003, 1'b1, "rr grant3");
        ack_event("rr3");
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h0) begin
            $display("FAIL rr drained: got %h expected 0", d);
            n_fail++;
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        // Leave an old pending[2] masked, then re-edge it as the grant fires.
        bus_write(2'd1, 32'h8000_0000);
        in_port[2] = 1'b1;
        repeat (12) tick();
        in_port[2] = 1'b0;
        repeat (12) tick();
        in_port[2] = 1'b1;
        repeat (5) tick();
        bus_write(2'd1, 32'h8000_0004);
        tick();
        n_checks++;
        if (dut.valid !== 1'b1 || dut.channel !== 3'd2 || dut.pending !== 4'h4) begin
            $display("FAIL grant+set: valid %b ch %0d pending %h expected 1 2 4",
                     dut.valid, dut.channel, dut.pending);
            n_fail++;
        end
        ack_event("sim grant");
        wait_event(32'h8000_0002, 1'b1, "sim regrant");
        ack_event("sim regrant");

        // W1C coinciding with a new edge on channel 2
        bus_write(2'd1, 32'h8000_0000);
        in_port[2] = 1'b0;
        repeat (12) tick();
        in_port[2] = 1'b1;
        repeat (6) tick();
        bus_write(2'd3, 32'h4);
        n_checks++;
        if (dut.pending !== 4'h4) begin
            $display("FAIL w1c+set: got %h expected 4", dut.pending);
            n_fail++;
        end
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h0) begin
            $display("FAIL w1c clear: got %h expected 0", d);
            n_fail++;
        end
    endtask

    task automatic test_mask_irq_en();
        logic [31:0] d;
        do_reset();
        bus_write(2'd1, 32'h8000_0000);
        in_port = 4'b0011;
        repeat (12) tick();
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h3) begin
            $display("FAIL mask pending: got %h expected 3", d);
            n_fail++;
        end
        tick();
        n_checks++;
        if (bus.readdata !== 32'h0 || bus.irq !== 1'b0) begin
            $display("FAIL mask hold: event %h irq %b expected 0 0", bus.readdata, bus.irq);
            n_fail++;
        end
        bus_write(2'd1, 32'h8000_0002);
        wait_event(32'h8000_0001, 1'b1, "mask ch1");
        ack_event("mask ch1");

        // irq_en off: event is held but irq stays low
        bus_write(2'd1, 32'h0000_0001);
        tick();
        tick();
        n_checks++;
        if (bus.readdata !== 32'h8000_0000 || bus.irq !== 1'b0) begin
            $display("FAIL irq_en off: event %h irq %b expected 80000000 0",
                     bus.readdata, bus.irq);
            n_fail++;
        end
        bus_write(2'd1, 32'h8000_0001);
        n_checks++;
        if (bus.irq !== 1'b0) begin
            $display("FAIL irq_en edge: got %b expected 0", bus.irq);
            n_fail++;
        end
        tick();
        n_checks++;
        if (bus.irq !== 1'b1) begin
            $display("FAIL irq_en on: got %b expected 1", bus.irq);
            n_fail++;
        end
        ack_event("irq_en");
    endtask

    task automatic test_stray_readback();
        logic [31:0] d;
        bus_write(2'd2, 32'hFFFF_FFFF);
        tick();
        n_checks++;
        if (bus.readdata !== 32'h0 || bus.irq !== 1'b0) begin
            $display("FAIL stray ack: event %h irq %b expected 0 0", bus.readdata, bus.irq);
            n_fail++;
        end
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h3) begin
            $display("FAIL read stable: got %h expected 3", d);
            n_fail++;
        end
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h8000_0001) begin
            $display("FAIL read ctrl: got %h expected 80000001", d);
            n_fail++;
        end
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h0) begin
            $display("FAIL read pending: got %h expected 0", d);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_op();
        bus_write(2'd1, 32'h8000_000F);
        in_port = 4'b1011;
        wait_event(32'h8000_0003, 1'b1, "pre-reset ch3");
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.readdata !== 32'h0 || bus.irq !== 1'b0) begin
            $display("FAIL async reset bus: readdata %h irq %b expected 0 0",
                     bus.readdata, bus.irq);
            n_fail++;
        end
        n_checks++;
        if (dut.valid !== 1'b0 || dut.pending !== 4'h0 || dut.mask !== 4'h0) begin
            $display("FAIL async reset state: valid %b pending %h mask %h expected 0 0 0",
                     dut.valid, dut.pending, dut.mask);
            n_fail++;
        end
        in_port = 4'b1001;
        tick();
        tick();
        reset_n = 1'b1;
        bus_write(2'd1, 32'h8000_000F);
        wait_event(32'h8000_0000, 1'b1, "post-reset ch0");
        ack_event("post-reset ch0");
        wait_event(32'h8000_0003, 1'b1, "post-reset ch3");
        ack_event("post-reset ch3");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_debounce();
        test_round_robin();
        test_simultaneous();
        test_mask_irq_en();
        test_stray_readback();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
